// File: rtl/minibus_pkg.sv
// Shared minibus types and limits for the multi-initiator front end.
package minibus_pkg;

    localparam int unsigned MINIBUS_MAX_MASTERS = 8;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority first-set-bit search: returns the first requester at or
// after ptr, wrapping modulo COUNT.
module rr_picker
    import minibus_pkg::*;
#(
    parameter int unsigned COUNT = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [COUNT-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [IDX_W:0] cand;

    // Walk candidates ptr, ptr+1, ... keeping the first one that requests.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < MINIBUS_MAX_MASTERS; i++) begin
            if (i < COUNT) begin
                cand = {1'b0, ptr} + (IDX_W+1)'(i);
                if (cand >= (IDX_W+1)'(COUNT)) begin
                    cand = cand - (IDX_W+1)'(COUNT);
                end
                if (!found && req[cand[IDX_W-1:0]]) begin
                    found = 1'b1;
                    idx   = cand[IDX_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/minibus_arbiter.sv
// Round-robin arbiter merging several minibus initiators onto one downstream
// port. One transaction at a time; the grant is held until dn_ready.
module minibus_arbiter
    import minibus_pkg::*;
#(
    parameter int unsigned MASTER_COUNT = 2,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    localparam int unsigned IDX_W       = $clog2(MASTER_COUNT)
) (
    input  logic                                 clk,
    input  logic                                 nrst,
    input  logic [MASTER_COUNT-1:0]              up_ren,
    input  logic [MASTER_COUNT-1:0]              up_wen,
    input  logic [MASTER_COUNT-1:0][ADDR_W-1:0]  up_addr,
    input  logic [MASTER_COUNT-1:0][DATA_W-1:0]  up_wdata,
    output logic [DATA_W-1:0]                    up_rdata,
    output logic [MASTER_COUNT-1:0]              up_ready,
    output logic                                 dn_ren,
    output logic                                 dn_wen,
    output logic [ADDR_W-1:0]                    dn_addr,
    output logic [DATA_W-1:0]                    dn_wdata,
    input  logic [DATA_W-1:0]                    dn_rdata,
    input  logic                                 dn_ready,
    output logic [IDX_W-1:0]                     grant_id,
    output logic                                 busy
);

    arb_state_t              state;
    logic [IDX_W-1:0]        rr_ptr;
    logic [IDX_W-1:0]        next_ptr;
    logic [MASTER_COUNT-1:0] req;
    logic                    own_req;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_found;

    assign req      = up_ren | up_wen;
    assign own_req  = req[grant_id];
    assign busy     = (state == ARB_BUSY);
    assign next_ptr = (grant_id == IDX_W'(MASTER_COUNT - 1)) ? '0 : grant_id + IDX_W'(1);

    rr_picker #(
        .COUNT (MASTER_COUNT),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (req),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Arbitration FSM: grant in idle, release on completion or on a dropped request.
    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state    <= ARB_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_idx;
                        state    <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (dn_ready) begin
                        rr_ptr <= next_ptr;
                        state  <= ARB_IDLE;
                    end else if (!own_req) begin
                        // Aborted transfer: owner keeps top priority next round.
                        state <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // Downstream mirrors the owner while busy; everything is zero otherwise.
    always_comb begin
        dn_ren   = 1'b0;
        dn_wen   = 1'b0;
        dn_addr  = '0;
        dn_wdata = '0;
        up_rdata = '0;
        up_ready = '0;
        if (state == ARB_BUSY) begin
            dn_ren             = up_ren[grant_id];
            dn_wen             = up_wen[grant_id];
            dn_addr            = up_addr[grant_id];
            dn_wdata           = up_wdata[grant_id];
            up_rdata           = dn_rdata;
            up_ready[grant_id] = dn_ready;
        end
    end

endmodule

// File: tb/tb_minibus_arbiter.sv
// Directed bench for minibus_arbiter: per-cycle vector table plus
// multi-cycle sequences (contention, long slave, abort, reset, wrap).
module tb_minibus_arbiter;

    logic clk;
    logic nrst;

    // Two-initiator instance
    logic [1:0]        ren2, wen2;
    logic [1:0][31:0]  addr2, wdata2;
    logic [31:0]       rdata2;
    logic [1:0]        ready2;
    logic              dn_ren2, dn_wen2;
    logic [31:0]       dn_addr2, dn_wdata2, dn_rdata2;
    logic              dn_ready2;
    logic [0:0]        gid2;
    logic              busy2;

    // Three-initiator instance for wrap-around
    logic [2:0]        ren3, wen3;
    logic [2:0][31:0]  addr3, wdata3;
    logic [31:0]       rdata3;
    logic [2:0]        ready3;
    logic              dn_ren3, dn_wen3;
    logic [31:0]       dn_addr3, dn_wdata3, dn_rdata3;
    logic              dn_ready3;
    logic [1:0]        gid3;
    logic              busy3;

    int checks;
    int failures;

    minibus_arbiter #(.MASTER_COUNT(2), .ADDR_W(32), .DATA_W(32)) dut2 (
        .clk(clk), .nrst(nrst),
        .up_ren(ren2), .up_wen(wen2), .up_addr(addr2), .up_wdata(wdata2),
        .up_rdata(rdata2), .up_ready(ready2),
        .dn_ren(dn_ren2), .dn_wen(dn_wen2), .dn_addr(dn_addr2), .dn_wdata(dn_wdata2),
        .dn_rdata(dn_rdata2), .dn_ready(dn_ready2),
        .grant_id(gid2), .busy(busy2)
    );

    minibus_arbiter #(.MASTER_COUNT(3), .ADDR_W(32), .DATA_W(32)) dut3 (
        .clk(clk), .nrst(nrst),
        .up_ren(ren3), .up_wen(wen3), .up_addr(addr3), .up_wdata(wdata3),
        .up_rdata(rdata3), .up_ready(ready3),
        .dn_ren(dn_ren3), .dn_wen(dn_wen3), .dn_addr(dn_addr3), .dn_wdata(dn_wdata3),
        .dn_rdata(dn_rdata3), .dn_ready(dn_ready3),
        .grant_id(gid3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  ren;
        logic [1:0]  wen;
        logic        rdy;
        logic [31:0] rdata;
        logic        e_busy;
        logic        e_gid;
        logic        e_dren;
        logic        e_dwen;
        logic [31:0] e_addr;
        logic [1:0]  e_ready;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(input logic [1:0] ren, input logic [1:0] wen, input logic rdy,
                                input logic [31:0] rdata, input logic e_busy, input logic e_gid,
                                input logic e_dren, input logic e_dwen, input logic [31:0] e_addr,
                                input logic [1:0] e_ready, input logic [31:0] e_rdata);
        vec_t v;
        v.ren = ren; v.wen = wen; v.rdy = rdy; v.rdata = rdata;
        v.e_busy = e_busy; v.e_gid = e_gid; v.e_dren = e_dren; v.e_dwen = e_dwen;
        v.e_addr = e_addr; v.e_ready = e_ready; v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%h expected=0x%h", name, act, exp);
        end
    endtask

    task automatic edge_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nrst = 1'b1;
        ren2 = '0; wen2 = '0; dn_ready2 = 1'b0; dn_rdata2 = '0;
        ren3 = '0; wen3 = '0; dn_ready3 = 1'b0; dn_rdata3 = '0;
        @(posedge clk);
        #1;
        nrst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        nrst     = 1'b1;
        ren2 = '0; wen2 = '0; dn_ready2 = 1'b0; dn_rdata2 = '0;
        ren3 = '0; wen3 = '0; dn_ready3 = 1'b0; dn_rdata3 = '0;
        addr2[0] = 32'h0000_0010; addr2[1] = 32'h0000_4000;
        wdata2[0] = 32'h0;        wdata2[1] = 32'h0000_55AA;
        for (int i = 0; i < 3; i++) begin
            addr3[i]  = 32'h100 * (i + 1);
            wdata3[i] = '0;
        end

        //          ren    wen    rdy   rdata          busy gid dren dwen addr          ready  e_rdata
        vecs[0]  = mk(2'b00, 2'b00, 1'b0, 32'h0,         0, 0, 0, 0, 32'h0,        2'b00, 32'h0);
        vecs[1]  = mk(2'b01, 2'b00, 1'b0, 32'h0,         0, 0, 0, 0, 32'h0,        2'b00, 32'h0);
        vecs[2]  = mk(2'b01, 2'b00, 1'b0, 32'h0,         1, 0, 1, 0, 32'h10,       2'b00, 32'h0);
        vecs[3]  = mk(2'b01, 2'b00, 1'b1, 32'hDEADBEEF,  1, 0, 1, 0, 32'h10,       2'b01, 32'hDEADBEEF);
        vecs[4]  = mk(2'b00, 2'b00, 1'b0, 32'h0,         0, 0, 0, 0, 32'h0,        2'b00, 32'h0);
        vecs[5]  = mk(2'b00, 2'b00, 1'b1, 32'h1234,      0, 0, 0, 0, 32'h0,        2'b00, 32'h0);
        vecs[6]  = mk(2'b11, 2'b00, 1'b0, 32'h0,         0, 0, 0, 0, 32'h0,        2'b00, 32'h0);
        vecs[7]  = mk(2'b11, 2'b00, 1'b1, 32'h0,         1, 1, 1, 0, 32'h4000,     2'b10, 32'h0);
        vecs[8]  = mk(2'b11, 2'b00, 1'b0, 32'h0,         0, 1, 0, 0, 32'h0,        2'b00, 32'h0);
        vecs[9]  = mk(2'b11, 2'b00, 1'b1, 32'h0BAD,      1, 0, 1, 0, 32'h10,       2'b01, 32'h0BAD);
        vecs[10] = mk(2'b11, 2'b00, 1'b0, 32'h0,         0, 0, 0, 0, 32'h0,        2'b00, 32'h0);
        vecs[11] = mk(2'b01, 2'b10, 1'b0, 32'h7777,      1, 1, 0, 1, 32'h4000,     2'b00, 32'h7777);
        vecs[12] = mk(2'b01, 2'b10, 1'b1, 32'h0,         1, 1, 0, 1, 32'h4000,     2'b10, 32'h0);
        vecs[13] = mk(2'b01, 2'b00, 1'b0, 32'h0,         0, 1, 0, 0, 32'h0,        2'b00, 32'h0);
        vecs[14] = mk(2'b01, 2'b00, 1'b1, 32'hCAFE,      1, 0, 1, 0, 32'h10,       2'b01, 32'hCAFE);
        vecs[15] = mk(2'b00, 2'b00, 1'b0, 32'h0,         0, 0, 0, 0, 32'h0,        2'b00, 32'h0);

        // Reset values while reset is held
        #2;
        check("reset busy", 32'(busy2), 32'h0);
        check("reset grant_id", 32'(gid2), 32'h0);
        check("reset dn_ren", 32'(dn_ren2), 32'h0);
        check("reset dn_addr", dn_addr2, 32'h0);
        check("reset up_ready", 32'(ready2), 32'h0);
        check("reset up_rdata", rdata2, 32'h0);
        do_reset();

        // Per-cycle vector table
        for (int i = 0; i < 16; i++) begin
            edge_drive();
            ren2 = vecs[i].ren; wen2 = vecs[i].wen;
            dn_ready2 = vecs[i].rdy; dn_rdata2 = vecs[i].rdata;
            #2;
            check($sformatf("row%0d busy", i),     32'(busy2),   32'(vecs[i].e_busy));
            check($sformatf("row%0d grant_id", i), 32'(gid2),    32'(vecs[i].e_gid));
            check($sformatf("row%0d dn_ren", i),   32'(dn_ren2), 32'(vecs[i].e_dren));
            check($sformatf("row%0d dn_wen", i),   32'(dn_wen2), 32'(vecs[i].e_dwen));
            check($sformatf("row%0d dn_addr", i),  dn_addr2,     vecs[i].e_addr);
            check($sformatf("row%0d up_ready", i), 32'(ready2),  32'(vecs[i].e_ready));
            check($sformatf("row%0d up_rdata", i), rdata2,       vecs[i].e_rdata);
        end

        // Contention from reset: 20 transactions alternate 0,1,0,1...
        begin
            int  tally [2];
            int  exp_g;
            logic found;
            do_reset();
            tally[0] = 0; tally[1] = 0;
            exp_g = 0;
            ren2 = 2'b11; dn_ready2 = 1'b1;
            for (int t = 0; t < 20; t++) begin
                found = 1'b0;
                for (int c = 0; c < 8 && !found; c++) begin
                    @(posedge clk);
                    #3;
                    if (ready2 != 2'b00) found = 1'b1;
                end
                check($sformatf("contention ready seen t%0d", t), 32'(found), 32'h1);
                check($sformatf("contention up_ready t%0d", t), 32'(ready2), 32'(1 << exp_g));
                check($sformatf("contention grant_id t%0d", t), 32'(gid2), 32'(exp_g));
                tally[gid2]++;
                exp_g = 1 - exp_g;
            end
            check("contention tally m0", 32'(tally[0]), 32'd10);
            check("contention tally m1", 32'(tally[1]), 32'd10);
            ren2 = 2'b00; dn_ready2 = 1'b0;
        end

        // Long slave: m1 write to 0x4000 stalls 5 cycles while m0 waits
        do_reset();
        ren2 = 2'b01;
        edge_drive();
        dn_ready2 = 1'b1;
        #2;
        check("long warmup m0 ready", 32'(ready2), 32'h1);
        edge_drive();
        wen2 = 2'b10; dn_ready2 = 1'b0;
        edge_drive();
        for (int k = 0; k < 5; k++) begin
            #2;
            check($sformatf("long dn_addr c%0d", k), dn_addr2, 32'h4000);
            check($sformatf("long dn_wen c%0d", k), 32'(dn_wen2), 32'h1);
            check($sformatf("long up_ready c%0d", k), 32'(ready2), 32'h0);
            check($sformatf("long dn_wdata c%0d", k), dn_wdata2, 32'h55AA);
            edge_drive();
        end
        dn_ready2 = 1'b1;
        #2;
        check("long m1 ready", 32'(ready2), 32'h2);
        edge_drive();
        wen2 = 2'b00; dn_ready2 = 1'b0;
        #2;
        check("long idle gap", 32'(busy2), 32'h0);
        edge_drive();
        #2;
        check("long m0 next grant", 32'(gid2), 32'h0);
        check("long m0 dn_ren", 32'(dn_ren2), 32'h1);
        check("long m0 dn_addr", dn_addr2, 32'h10);

        // Abort: m0 drops ren two cycles into a stalled read
        do_reset();
        ren2 = 2'b01;
        edge_drive();
        edge_drive();
        ren2 = 2'b00;
        #2;
        check("abort dn_ren same cycle", 32'(dn_ren2), 32'h0);
        check("abort still busy", 32'(busy2), 32'h1);
        edge_drive();
        #1;
        check("abort back to idle", 32'(busy2), 32'h0);
        ren2 = 2'b11;
        edge_drive();
        #1;
        check("abort regrant busy", 32'(busy2), 32'h1);
        check("abort regrant m0", 32'(gid2), 32'h0);
        ren2 = 2'b00;

        // Reset mid-transaction, then a fresh m1 request
        do_reset();
        ren2 = 2'b10;
        edge_drive();
        dn_rdata2 = 32'hFFFF_0000;
        #1;
        check("midreset pre busy", 32'(busy2), 32'h1);
        check("midreset pre grant", 32'(gid2), 32'h1);
        check("midreset pre rdata", rdata2, 32'hFFFF_0000);
        nrst = 1'b1;
        #1;
        check("midreset busy", 32'(busy2), 32'h0);
        check("midreset grant", 32'(gid2), 32'h0);
        check("midreset dn_ren", 32'(dn_ren2), 32'h0);
        check("midreset dn_addr", dn_addr2, 32'h0);
        check("midreset up_rdata", rdata2, 32'h0);
        #1;
        nrst = 1'b0;
        edge_drive();
        check("midreset regrant busy", 32'(busy2), 32'h1);
        check("midreset regrant m1", 32'(gid2), 32'h1);
        dn_ready2 = 1'b1;
        #1;
        check("midreset regrant ready", 32'(ready2), 32'h2);
        edge_drive();
        ren2 = 2'b00; dn_ready2 = 1'b0; dn_rdata2 = '0;

        // Wrap-around with three initiators
        do_reset();
        ren3 = 3'b010;
        edge_drive();
        check("wrap setup grant 1", 32'(gid3), 32'h1);
        dn_ready3 = 1'b1;
        edge_drive();
        check("wrap rr_ptr 2", 32'(dut3.rr_ptr), 32'h2);
        ren3 = 3'b101; dn_ready3 = 1'b0;
        edge_drive();
        check("wrap grant 2 first", 32'(gid3), 32'h2);
        dn_ready3 = 1'b1;
        #1;
        check("wrap up_ready 2", 32'(ready3), 32'h4);
        edge_drive();
        check("wrap rr_ptr 0", 32'(dut3.rr_ptr), 32'h0);
        dn_ready3 = 1'b0;
        edge_drive();
        check("wrap grant 0 second", 32'(gid3), 32'h0);
        dn_ready3 = 1'b1;
        edge_drive();
        check("wrap rr_ptr 1", 32'(dut3.rr_ptr), 32'h1);
        dn_ready3 = 1'b0;
        edge_drive();
        check("wrap grant 2 third", 32'(gid3), 32'h2);
        ren3 = 3'b000;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
